nth_root_seq: RTL and testbench
===============================

Name: nth_root_seq

Overview:
- Parametrised, multiplier-based successor to the integer-power bit-search root unit.
- Computes the fixed-point n-th root of an unsigned integer radicand by MSB-first bit search.
- Candidate powers are built by iterative sequential multiplication, not a combinational power operator.
- Valid/ready handshakes on both sides and exponent range checking. Sits between the operand buffer and the result formatter in the arithmetic datapath.

Parameters:
- IN_W, 10, radicand integer width.
- FRAC_W, 10, fractional bits of result.
- EXP_W, 3, exponent port width.
- N_MAX, 5, largest legal exponent; must satisfy N_MAX < 2**EXP_W.
- Derived, not overridable: OUT_W = IN_W+FRAC_W.
- Derived, not overridable: ACC_W = N_MAX*OUT_W.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, operand valid.
- in_ready, output, 1, block can accept operand.
- in_data_1, input, IN_W, radicand x (unsigned integer).
- in_data_2, input, EXP_W, exponent n.
- out_valid, output, 1, result valid; held until taken.
- out_ready, input, 1, downstream accepts result.
- out_data, output, OUT_W, floor(x^(1/n) * 2^FRAC_W).
- out_err, output, 1, exponent illegal; qualified by out_valid.

Behaviour:
- Clocking and reset: one clock domain, clk; reset is asynchronous and active-low, rst_n.
- Reset state: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_err=0, all internal registers 0. Applies at any time, including mid-computation; the in-flight operand is discarded.
- FSM states: IDLE, TRIAL, MUL, CMP, DONE.
- IDLE:
  - in_ready=1. Accept when in_valid&in_ready at a clock edge; latch x and n, clear result, bit index k=OUT_W-1.
  - If n==0 or n>N_MAX: go to DONE with out_err=1, out_data=0.
  - Otherwise: go to TRIAL.
- TRIAL (1 cycle): candidate c = result | (1<<k); acc <= c; mcnt <= 1.
- MUL (n-1 cycles; skipped when n==1): acc <= acc*c truncated to ACC_W (lossless by construction); mcnt++; leave when mcnt==n-1.
- CMP (1 cycle):
  - Target T = x << (n*FRAC_W), ACC_W wide.
  - If acc <= T: set bit k of result.
  - If k==0: go to DONE. Otherwise k--, go to TRIAL.
- Latency: exactly OUT_W*(n+1) edges from the accepting edge to out_valid=1 (n=2: 60 cycles). Illegal n: out_valid on the next edge.
- DONE:
  - out_valid=1; out_data and out_err stable.
  - On out_valid&out_ready: out_valid<=0, go to IDLE.
  - out_ready held low: hold indefinitely with no change.
- in_ready=0 in every state except IDLE. in_valid while busy is ignored, not queued.
- Back-to-back operation: the earliest next accept is the edge after the DONE handshake.
- x=0: result 0. n=1: result x<<FRAC_W (max 0xFFC00 at defaults).
- out_data changes only when entering DONE; it stays at its last value in IDLE.

Optional Feature:
- Macro: NTH_ROOT_EARLY_EXIT_EN.
- Defined: in CMP, if acc == T, set bit k and go directly to DONE. The remaining bits are necessarily 0, so out_data is identical to the full search; only latency shrinks, to (OUT_W-k)*(n+1) edges.
- Undefined: no equality check; latency is always OUT_W*(n+1), fully deterministic.

Test Plan:
- x=2, n=2, out_ready=1 -> out_data=0x005A8 (1448), out_err=0, out_valid after 60 cycles.
- x=4, n=2 -> out_data=0x00800. Latency 27 with NTH_ROOT_EARLY_EXIT_EN, 60 without.
- x=1023, n=5 -> out_data=0x00FFF. x=1000, n=3 -> 0x02800. x=1023, n=1 -> 0xFFC00. x=0, n=4 -> 0x00000.
- n=0 and n=6 (any x) -> out_err=1, out_data=0, out_valid one cycle after accept.
- out_ready low for 5 cycles in DONE, in_valid pulsed while busy -> out_valid and out_data held, in_ready=0, extra operand ignored; after handshake in_ready=1.
- rst_n asserted mid-MUL for x=2, n=3 -> outputs zero immediately (asynchronous). After release, a new x=8, n=3 yields 0x00800.

Source files
------------

// File: rtl/nth_root_seq.sv
`default_nettype none
// ============================================================================
// nth_root_seq : fixed-point n-th root by MSB-first bit search, with candidate
//                powers built by repeated multiplication.
// Optional macro : NTH_ROOT_EARLY_EXIT_EN (stop the search on an exact power)
// Revision       : 1.0
// ============================================================================
module nth_root_seq #(
  parameter int IN_W   = 10,
  parameter int FRAC_W = 10,
  parameter int EXP_W  = 3,
  parameter int N_MAX  = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_W-1:0]          in_data_1,
  input  logic [EXP_W-1:0]         in_data_2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IN_W+FRAC_W-1:0]   out_data,
  output logic                     out_err
);

  localparam int OUT_W = IN_W + FRAC_W;
  localparam int ACC_W = N_MAX * OUT_W;
  localparam int K_W   = $clog2(OUT_W);
  localparam int SH_W  = $clog2(ACC_W + 1);
  localparam logic [K_W-1:0] c_K_TOP = K_W'(OUT_W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TRIAL = 3'd1,
    S_MUL   = 3'd2,
    S_CMP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [IN_W-1:0]     r_x;
  logic [EXP_W-1:0]    r_n;
  logic [OUT_W-1:0]    r_res;
  logic [OUT_W-1:0]    r_c;
  logic [K_W-1:0]      r_k;
  logic [ACC_W-1:0]    r_acc;
  logic [EXP_W-1:0]    r_mcnt;
  logic [OUT_W-1:0]    r_out_data;
  logic                r_out_err;

  logic                w_n_bad;
  logic [OUT_W-1:0]    w_cand;
  logic [ACC_W-1:0]    w_prod;
  logic [SH_W-1:0]     w_sh;
  logic [ACC_W-1:0]    w_tgt;
  logic                w_le;
  logic [OUT_W-1:0]    w_res_upd;
  logic                w_fin;

  assign w_n_bad   = (in_data_2 == '0) || (in_data_2 > EXP_W'(N_MAX));
  assign w_cand    = r_res | (OUT_W'(1) << r_k);
  // c^n < 2^(n*OUT_W) <= 2^ACC_W, so truncating the product never loses bits
  assign w_prod    = r_acc * ACC_W'(r_c);
  assign w_sh      = SH_W'(r_n) * SH_W'(FRAC_W);
  assign w_tgt     = ACC_W'(r_x) << w_sh;
  assign w_le      = (r_acc <= w_tgt);
  assign w_res_upd = w_le ? r_c : r_res;

`ifdef NTH_ROOT_EARLY_EXIT_EN
  logic w_eq;
  // an exact power leaves every lower result bit at zero
  assign w_eq  = (r_acc == w_tgt);
  assign w_fin = (r_k == '0) || w_eq;
`else
  assign w_fin = (r_k == '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = w_n_bad ? S_DONE : S_TRIAL;
        end
      end
      S_TRIAL: begin
        w_state_nxt = (r_n == EXP_W'(1)) ? S_CMP : S_MUL;
      end
      S_MUL: begin
        if (r_mcnt == r_n - EXP_W'(1)) begin
          w_state_nxt = S_CMP;
        end
      end
      S_CMP: begin
        w_state_nxt = w_fin ? S_DONE : S_TRIAL;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x        <= '0;
      r_n        <= '0;
      r_res      <= '0;
      r_c        <= '0;
      r_k        <= '0;
      r_acc      <= '0;
      r_mcnt     <= '0;
      r_out_data <= '0;
      r_out_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_x   <= in_data_1;
            r_n   <= in_data_2;
            r_res <= '0;
            r_k   <= c_K_TOP;
            if (w_n_bad) begin
              r_out_data <= '0;
              r_out_err  <= 1'b1;
            end
          end
        end
        S_TRIAL: begin
          r_c    <= w_cand;
          r_acc  <= ACC_W'(w_cand);
          r_mcnt <= EXP_W'(1);
        end
        S_MUL: begin
          r_acc  <= w_prod;
          r_mcnt <= r_mcnt + EXP_W'(1);
        end
        S_CMP: begin
          r_res <= w_res_upd;
          if (w_fin) begin
            r_out_data <= w_res_upd;
            r_out_err  <= 1'b0;
          end else begin
            r_k <= r_k - K_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data = r_out_data;
  assign out_err  = r_out_err;

endmodule
`default_nettype wire

// File: tb/tb_nth_root_seq.sv
`default_nettype none
// Directed-vector bench for nth_root_seq: table of operands plus handshake,
// back-pressure and asynchronous-reset sequences.
module tb_nth_root_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_data_1;
  logic [2:0]  in_data_2;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_data;
  logic        out_err;

  int checks;
  int errors;

  nth_root_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data_1 (in_data_1),
    .in_data_2 (in_data_2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  x;
    logic [2:0]  n;
    logic [19:0] data;
    logic        err;
    int          lat;
    int          lat_ee;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Accept edge is followed by lat further edges until out_valid is seen.
  task automatic do_op(input logic [9:0] x, input logic [2:0] n,
                       output int lat, output logic [19:0] d, output logic e);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data_1 = x;
    in_data_2 = n;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 2000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) begin
      errors++;
      checks++;
      $display("FAIL timeout: out_valid never rose for x=%0d n=%0d", x, n);
    end
    d = out_data;
    e = out_err;
  endtask

  initial begin
    int          lat;
    int          wait_cnt;
    logic [19:0] d;
    logic        e;

    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data_1 = '0;
    in_data_2 = '0;
    out_ready = 1'b1;

    vt[0]  = '{10'd2,    3'd2, 20'h005A8, 1'b0, 60,  60};
    vt[1]  = '{10'd4,    3'd2, 20'h00800, 1'b0, 60,  27};
    vt[2]  = '{10'd1023, 3'd5, 20'h00FFF, 1'b0, 120, 120};
    vt[3]  = '{10'd1000, 3'd3, 20'h02800, 1'b0, 80,  36};
    vt[4]  = '{10'd1023, 3'd1, 20'hFFC00, 1'b0, 40,  20};
    vt[5]  = '{10'd0,    3'd4, 20'h00000, 1'b0, 100, 100};
    vt[6]  = '{10'd1023, 3'd2, 20'h07FEF, 1'b0, 60,  60};
    vt[7]  = '{10'd3,    3'd2, 20'h006ED, 1'b0, 60,  60};
    vt[8]  = '{10'd243,  3'd5, 20'h00C00, 1'b0, 120, 60};
    vt[9]  = '{10'd1,    3'd3, 20'h00400, 1'b0, 80,  40};
    vt[10] = '{10'd5,    3'd0, 20'h00000, 1'b1, 0,   0};
    vt[11] = '{10'd7,    3'd6, 20'h00000, 1'b1, 0,   0};
    vt[12] = '{10'd1023, 3'd7, 20'h00000, 1'b1, 0,   0};
    vt[13] = '{10'd16,   3'd4, 20'h00800, 1'b0, 100, 45};

    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready",  {31'd0, in_ready},  32'd1);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset out_data",  {12'd0, out_data},  32'd0);
    chk("reset out_err",   {31'd0, out_err},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      do_op(vt[i].x, vt[i].n, lat, d, e);
      chk($sformatf("vec%0d data", i), {12'd0, d}, {12'd0, vt[i].data});
      chk($sformatf("vec%0d err", i), {31'd0, e}, {31'd0, vt[i].err});
`ifdef NTH_ROOT_EARLY_EXIT_EN
      chk($sformatf("vec%0d latency", i), lat, vt[i].lat_ee);
`else
      chk($sformatf("vec%0d latency", i), lat, vt[i].lat);
`endif
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d idle out_valid", i), {31'd0, out_valid}, 32'd0);
      chk($sformatf("vec%0d idle in_ready", i), {31'd0, in_ready}, 32'd1);
      chk($sformatf("vec%0d idle data hold", i), {12'd0, out_data}, {12'd0, vt[i].data});
    end

    // Back-pressure in DONE, and an operand offered while busy must be dropped.
    out_ready = 1'b0;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data_1 = 10'd2;
    in_data_2 = 3'd2;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("busy in_ready", {31'd0, in_ready}, 32'd0);
    in_valid  = 1'b1;
    in_data_1 = 10'd1023;
    in_data_2 = 3'd1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_cnt = 0;
    while (!out_valid && wait_cnt < 2000) begin
      @(posedge clk);
      #1;
      wait_cnt++;
    end
    chk("hold reached done", {31'd0, out_valid}, 32'd1);
    for (int j = 0; j < 5; j++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold%0d out_valid", j), {31'd0, out_valid}, 32'd1);
      chk($sformatf("hold%0d out_data", j), {12'd0, out_data}, 32'h005A8);
      chk($sformatf("hold%0d in_ready", j), {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hold release out_valid", {31'd0, out_valid}, 32'd0);
    chk("hold release in_ready", {31'd0, in_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("dropped operand not queued", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset while the multiplier loop is running.
    @(negedge clk);
    in_valid  = 1'b1;
    in_data_1 = 10'd2;
    in_data_2 = 3'd3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("busy keeps old out_data", {12'd0, out_data}, 32'h005A8);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst out_data",  {12'd0, out_data},  32'd0);
    chk("async rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("async rst in_ready",  {31'd0, in_ready},  32'd1);
    chk("async rst out_err",   {31'd0, out_err},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(10'd8, 3'd3, lat, d, e);
    chk("post-reset data", {12'd0, d}, 32'h00800);
    chk("post-reset err", {31'd0, e}, 32'd0);
`ifdef NTH_ROOT_EARLY_EXIT_EN
    chk("post-reset latency", lat, 36);
`else
    chk("post-reset latency", lat, 80);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
